// File: rtl/mat_mem_server.sv
// Word-addressed matrix store: fixed RD_LATENCY read with mem_busy held high, then a one-cycle data_valid pulse.
// No queueing: requests during a read are dropped; the host write port is always accepted.
module mat_mem_server #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  mem_busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_err,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = 32'(wr_addr) < 32'(DEPTH);
  assign rd_ok = 32'(addr_q)  < 32'(DEPTH);

  // Array is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      mem_busy   <= 1'b0;
      data_valid <= 1'b0;
      addr_err   <= 1'b0;
      data_out   <= '0;
    end else begin
      data_valid <= 1'b0;
      addr_err   <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (init_in) begin
            state    <= BUSY;
            addr_q   <= addr_in;
            cnt      <= 4'(RD_LATENCY);
            mem_busy <= 1'b1;
          end else begin
            state    <= IDLE;
            mem_busy <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // Capture reads the array before any same-edge write lands.
          if (cnt == 4'd1) begin
            state      <= RESP;
            mem_busy   <= 1'b0;
            data_valid <= 1'b1;
            if (rd_ok) begin
              data_out <= mem[addr_q[IW-1:0]];
            end else begin
              data_out <= '0;
              addr_err <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
